// File: rtl/mod_butterfly_pipe.sv
// Two-stage modular add/sub/butterfly pipeline with ready/valid flow control.
// S1 captures raw sum/difference and transaction context; S2 applies the modular correction.
module mod_butterfly_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              out_err,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned EXT_W = DATA_W + 1;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_BFLY = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  typedef struct packed {
    logic [1:0]        mode;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [EXT_W-1:0]  sum;
    logic [EXT_W-1:0]  diff;
    logic              err;
  } s1_t;

  // Stage 1 registers
  logic s1_valid_q, s1_valid_d;
  s1_t  s1_q, s1_d;

  // Stage 2 (output) registers
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out0_q, out0_d;
  logic [DATA_W-1:0] out1_q, out1_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  // Flow control
  logic s2_adv_c;
  logic s1_adv_c;
  logic consume_c;

  // Corrected arithmetic from S1 contents
  logic [EXT_W-1:0] add_ext_c;
  logic [EXT_W-1:0] sub_ext_c;
  logic [DATA_W-1:0] add_c;
  logic [DATA_W-1:0] sub_c;

  assign s2_adv_c  = !out_valid_q || out_ready;
  assign s1_adv_c  = !s1_valid_q || s2_adv_c;
  assign consume_c = out_valid_q && out_ready;
  assign in_ready  = s1_adv_c;

  assign out_valid = out_valid_q;
  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_err   = out_err_q;
  assign op_count  = op_count_q;

  // S1 next state: capture operands, raw sum/difference and the range flag
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.mode = mode;
        s1_d.q    = q;
        s1_d.a    = a;
        s1_d.b    = b;
        s1_d.sum  = EXT_W'(a) + EXT_W'(b);
        s1_d.diff = EXT_W'(a) - EXT_W'(b);
        s1_d.err  = (mode != MODE_PASS) &&
                    ((q == '0) || (a >= q) || (b >= q));
      end
    end
  end

  // Modular correction; diff MSB is the sign of the DATA_W+1-bit difference
  always_comb begin
    add_ext_c = s1_q.sum;
    if (s1_q.sum >= EXT_W'(s1_q.q)) begin
      add_ext_c = s1_q.sum - EXT_W'(s1_q.q);
    end
    sub_ext_c = s1_q.diff;
    if (s1_q.diff[DATA_W]) begin
      sub_ext_c = s1_q.diff + EXT_W'(s1_q.q);
    end
    add_c = DATA_W'(add_ext_c);
    sub_c = DATA_W'(sub_ext_c);
  end

  // S2 next state: output mapping, held while the consumer stalls
  always_comb begin
    out_valid_d = out_valid_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_err_d   = out_err_q;
    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_err_d = s1_q.err;
        case (s1_q.mode)
          MODE_ADD: begin
            out0_d = add_c;
            out1_d = '0;
          end
          MODE_SUB: begin
            out0_d = sub_c;
            out1_d = '0;
          end
          MODE_BFLY: begin
            out0_d = add_c;
            out1_d = sub_c;
          end
          default: begin
            out0_d = s1_q.a;
            out1_d = s1_q.b;
          end
        endcase
      end
    end
  end

  // Completed-transaction counter, wraps naturally
  always_comb begin
    op_count_d = op_count_q;
    if (consume_c) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_err_q   <= out_err_d;
      op_count_q  <= op_count_d;
    end
  end

endmodule

// File: doc/mod_butterfly_pipe.md
MOD_BUTTERFLY_PIPE -- requirements
Module: mod_butterfly_pipe

Interface
REQ-001 Parameter DATA_W, default 16: operand, modulus and result width in bits.
REQ-002 Parameter CNT_W, default 16: width of the completed-transaction counter.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block accepts the input this cycle.
- mode  input  2  operation: 00 add, 01 sub, 10 butterfly, 11 pass.
- q  input  DATA_W  modulus, sampled with each transaction.
- a  input  DATA_W  operand 0.
- b  input  DATA_W  operand 1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out0  output  DATA_W  primary result.
- out1  output  DATA_W  secondary result (butterfly or pass only).
- out_err  output  1  operand range error for this result.
- op_count  output  CNT_W  number of results consumed.

Function
REQ-004 A transfer SHALL occur on a rising clk edge when in_valid and in_ready are both 1; an output consumption SHALL occur when out_valid and out_ready are both 1.
REQ-005 The pipeline SHALL have two register stages, S1 (raw sum/difference) and S2 (modular correction); with no backpressure, the result SHALL appear on out* two cycles after acceptance.
REQ-006 S2 SHALL advance when S2 is empty or out_ready=1; S1 SHALL advance when S1 is empty or S2 advances; in_ready SHALL equal the S1 advance condition, combinationally.
REQ-007 Throughput SHALL be one transaction per cycle while out_ready=1, with no bubbles.
REQ-008 With out_ready=0, out_valid, out0, out1 and out_err SHALL hold stable; no data SHALL be lost or duplicated.
REQ-009 S1 SHALL compute sum=a+b at DATA_W+1 bits and diff=a-b at DATA_W+1 bits signed, and register q, mode and the error flag.
REQ-010 S2 SHALL produce add = (sum>=q) ? sum-q : sum, and sub = (diff<0) ? diff+q : diff, truncated to DATA_W.
REQ-011 Output mapping SHALL be:
- mode 00: out0=add, out1=0.
- mode 01: out0=sub, out1=0.
- mode 10: out0=add, out1=sub.
- mode 11: out0=a, out1=b, unmodified.
REQ-012 out_err SHALL be 1 when a>=q or b>=q, or when q=0. The arithmetic outputs SHALL still follow REQ-010 in that case. In mode 11, out_err SHALL be 0.
REQ-013 op_count SHALL increment by 1 on each output consumption and wrap from 2^CNT_W-1 to 0.
REQ-014 Changing q or mode between transactions SHALL affect only subsequent transactions; in-flight results SHALL use their captured values.
REQ-015 Simultaneous acceptance and consumption in the same cycle SHALL be supported when the pipeline is full and out_ready=1.

Reset
REQ-016 When reset=0, independent of clk, the block SHALL clear the following within the same delta: out_valid=0, out0=0, out1=0, out_err=0, op_count=0, and all stage valid bits.
REQ-017 in_ready SHALL be 1 during reset and in the first cycle after release; in_ready follows REQ-006, and both stages are empty at that point.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight transactions; no result for them SHALL appear after release.

Verification
REQ-019 Add: q=251, mode=00, a=200, b=100, out_ready=1 -> two cycles later out0=49, out1=0, out_err=0, op_count=1.
REQ-020 Butterfly: q=251, mode=10, a=250, b=1 -> out0=0, out1=249. Then a=10, b=20 -> out0=30, out1=241 on the next cycle, with no bubble.
REQ-021 Backpressure: stream 4 sub transactions (q=251, a=i, b=i+1 for i=0..3) while out_ready is held 0 for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs stay stable, then all four results equal 250 in order and op_count=4.
REQ-022 Range error: q=251, mode=00, a=300, b=5 -> out_err=1. The same operands in mode 11 -> out0=300, out1=5, out_err=0.
REQ-023 Reset mid-flight: accept 2 transactions, assert reset for 1 cycle before either is consumed -> out_valid=0 immediately, no stale result after release, op_count=0.
REQ-024 Randomised: 1000 transactions with random mode, a, b < q, q in [2, 2^DATA_W-1] and random out_ready -> every result matches the (a±b) mod q model, and op_count equals the number of consumptions.
